encoder8_3: RTL and testbench
=============================

# encoder8_3

Registered 8-to-3 priority encoder with request capture and a valid/ready output handshake; the inverse of the team's 3-8 decoder. It captures rising edges on eight request lines into a pending register and presents the index of one pending request as a 3-bit code. The request is cleared when the consumer accepts it. It sits between asynchronous event sources (buttons, interrupts) and a consumer that drives a 3-8 decoder or dispatch logic.

## Interface
- SYNC_STAGES, default 2: synchronizer flops per `req` bit. Legal values are 0, 1 and 2; 0 means `req` is already synchronous to `clk`.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  8  request lines, one per source; bit i maps to code i.
- out_ready  in  1  consumer accepts the presented code.
- out_valid  out  1  `code` is valid.
- code  out  3  index of the presented request.
- pending  out  8  captured, not-yet-accepted requests.
- ovf  out  1  one-cycle pulse: a rising edge hit a bit that was already pending.

## Operation
- **Input path:** `req` passes through SYNC_STAGES flops, giving `req_s`. A register `req_q` holds the previous `req_s`. A rising edge is `req_s & ~req_q`.
- **Pending capture:** each rising edge sets the matching `pending` bit.
- **Overflow:** an edge on a bit that is already pending (and not being cleared this cycle) pulses `ovf` for one cycle. `pending` is unchanged.
- **FSM states:** IDLE and PRESENT.
- **IDLE:** if `pending != 0`, load `code` with the pick result, assert `out_valid`, go to PRESENT. Otherwise stay in IDLE.
- **PRESENT:** hold `code` and `out_valid` stable while `out_ready` is low.
  - On `out_valid && out_ready`: clear `pending[code]`, deassert `out_valid`, go to IDLE.
- **Pick rule (fixed priority):** the highest set index wins.
- **Simultaneous clear and edge on the same bit:** set wins, so the bit stays pending and `ovf` does not pulse.
- **Reset (at any time, including mid-handshake):** all state is cleared immediately.
  - Outputs: `out_valid` 0, `code` 0, `pending` 0, `ovf` 0.
  - Internal: FSM in IDLE; synchronizer flops, `req_q` and the round-robin pointer all 0.
  - A `req` line held high across reset is captured once as a new edge after release.
- **Width rules:** `code` is an unsigned 3-bit index. Round-robin arithmetic on the pointer is modulo 8.

## Timing
- All registers update on `clk` rising edge.
- **Latency:** from the first edge at which `req_s` shows a new 1 to `out_valid`, two clocks:
  - the pending bit is set after edge k;
  - `out_valid` rises after edge k+1.
- **End-to-end:** `req` input to `out_valid` takes SYNC_STAGES+2 clocks.
- **Throughput:** at most one accepted code per 2 clocks. There is one mandatory IDLE cycle after each accept.
- **`ovf`:** asserted in the cycle following the offending sampling edge; registered.
- **`pending`:** a direct register output. It reflects the cleared bit in the cycle after the accept.

## Configuration
- `ENCODER8_3_ROUND_ROBIN_EN` defined: rotating priority.
  - The search starts at index (last accepted code − 1) mod 8 and proceeds downward with wrap-around.
  - The pointer updates only on accept and resets to 0, so the first search starts at 7.
- Undefined: fixed priority, highest index wins; no pointer register.
- Both modes give identical results for the first grant after reset.

## Structure
- **Package `encoder8_3_pkg`:**
  - constants `NUM_REQ = 8` and `CODE_W = 3`;
  - FSM state enum {IDLE, PRESENT};
  - typedefs `req_vec_t` (8 bits) and `code_t` (3 bits).
- **Sub-module `encoder8_3_pick`:** combinational. Takes `pending` and the start index, returns the selected code plus `any`. The top instantiates it once; in fixed mode the start index is tied to 7.

## Test plan
- **Single request:** SYNC_STAGES=0; `req` = 8'h10 held.
  - `out_valid` rises 2 clocks later with `code` = 4.
  - `out_ready` = 1 for one cycle, then `pending` = 0 and `out_valid` = 0; no second grant while `req` stays high.
- **Fixed priority:** pulse `req` = 8'h85 in one cycle; `out_ready` tied 1.
  - Codes accepted in order 7, 2, 0, spaced 2 clocks apart.
- **Round robin (macro defined):** hold `pending` at 8'h81 by re-pulsing bits 7 and 0 after each accept.
  - Grants alternate 7, 0, 7, 0.
- **Backpressure:** `req` = 8'h02 then `out_ready` = 0 for 5 clocks.
  - `code` = 1 and `out_valid` = 1 stable throughout.
  - A new edge on bit 6 during the stall does not change `code`; 6 is granted after the accept of 1.
- **Overflow and simultaneous set/clear:**
  - A second edge on a pending bit 3 pulses `ovf` for exactly 1 cycle.
  - An edge on bit 3 in the same cycle it is accepted leaves `pending[3]` = 1 with no `ovf`.
- **Reset mid-handshake:** assert `rst` asynchronously while `out_valid` = 1 and `pending` = 8'hF0.
  - Outputs go to 0 immediately.
  - After release, with `req` = 8'h01 held, `code` = 0 is presented SYNC_STAGES+2 clocks later.

Source files
------------

// File: rtl/encoder8_3_pkg.sv
// Shared types and helpers for the encoder8_3 request encoder.
package encoder8_3_pkg;

  localparam int NUM_REQ = 8;
  localparam int CODE_W  = 3;

  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [CODE_W-1:0]  code_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  localparam code_t TOP_IDX = code_t'(NUM_REQ - 1);

  // Index k positions below base, wrapping modulo NUM_REQ.
  function automatic code_t idx_below(input code_t base, input int unsigned k);
    return code_t'(base - code_t'(k));
  endfunction

  function automatic req_vec_t code_onehot(input code_t c);
    req_vec_t v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/encoder8_3_pick.sv
// Combinational picker: scans pending downward from start (with wrap) and
// returns the first set index plus an any-set flag.
module encoder8_3_pick
  import encoder8_3_pkg::*;
(
  input  req_vec_t pending,
  input  code_t    start,
  output code_t    code,
  output logic     any
);

  always_comb begin
    code = '0;
    any  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any && pending[idx_below(start, i)]) begin
        code = idx_below(start, i);
        any  = 1'b1;
      end else begin
        code = code;
      end
    end
  end

endmodule

// File: rtl/encoder8_3.sv
// Registered 8-to-3 priority encoder with edge capture and valid/ready output.
// Optional macro ENCODER8_3_ROUND_ROBIN_EN selects rotating priority.
module encoder8_3
  import encoder8_3_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  req_vec_t req,
  input  logic     out_ready,
  output logic     out_valid,
  output code_t    code,
  output req_vec_t pending,
  output logic     ovf
);

  req_vec_t req_s;
  req_vec_t req_q;
  req_vec_t rise_s;
  req_vec_t clr_s;
  req_vec_t pending_d, pending_q;
  logic     ovf_d, ovf_q;
  logic     out_valid_d, out_valid_q;
  code_t    code_d, code_q;
  state_e   state_d, state_q;
  logic     accept_s;
  code_t    start_s;
  code_t    pick_code_s;
  logic     pick_any_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign req_s = req;
    end else begin : g_sync
      req_vec_t sync_d [SYNC_STAGES];
      req_vec_t sync_q [SYNC_STAGES];

      always_comb begin
        sync_d[0] = req;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= '{default: '0};
        end else begin
          sync_q <= sync_d;
        end
      end

      assign req_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

`ifdef ENCODER8_3_ROUND_ROBIN_EN
  code_t ptr_d, ptr_q;

  // Pointer remembers the last accepted code; the search begins just below it.
  always_comb begin
    if (accept_s) begin
      ptr_d = code_q;
    end else begin
      ptr_d = ptr_q;
    end
    start_s = idx_below(ptr_q, 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign start_s = TOP_IDX;
`endif

  encoder8_3_pick u_pick (
    .pending (pending_q),
    .start   (start_s),
    .code    (pick_code_s),
    .any     (pick_any_s)
  );

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    out_valid_d = out_valid_q;
    accept_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          code_d      = pick_code_s;
          out_valid_d = 1'b1;
          state_d     = PRESENT;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          accept_s    = 1'b1;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // A new edge on the bit being cleared re-sets it (set wins) and is not an overflow.
  always_comb begin
    rise_s    = req_s & ~req_q;
    if (accept_s) begin
      clr_s = code_onehot(code_q);
    end else begin
      clr_s = '0;
    end
    pending_d = (pending_q & ~clr_s) | rise_s;
    ovf_d     = |(rise_s & pending_q & ~clr_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      pending_q   <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      code_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_s;
      pending_q   <= pending_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      code_q      <= code_d;
    end
  end

  assign out_valid = out_valid_q;
  assign code      = code_q;
  assign pending   = pending_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_encoder8_3.sv
// Directed bench for encoder8_3 (SYNC_STAGES=0): per-cycle vector table plus
// hand sequences for backpressure, rotating priority and reset.
module tb_encoder8_3;

  localparam int SS = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] code;
  logic [7:0] pending;
  logic       ovf;

  int nchecks = 0;
  int nerr    = 0;

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic       valid;
    logic [2:0] code;
    logic [7:0] pend;
    logic       ovf;
  } vec_t;

  vec_t vecs [21];
  logic [2:0] exp_rr [4];
  logic [7:0] one8;

  encoder8_3 #(.SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .code      (code),
    .pending   (pending),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Single request held, fixed-order drain of 8'h85, overflow and set-wins.
    vecs[0]  = '{8'h10, 1'b0, 1'b0, 3'd0, 8'h10, 1'b0};
    vecs[1]  = '{8'h10, 1'b0, 1'b1, 3'd4, 8'h10, 1'b0};
    vecs[2]  = '{8'h10, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[3]  = '{8'h10, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[4]  = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[5]  = '{8'h85, 1'b1, 1'b0, 3'd0, 8'h85, 1'b0};
    vecs[6]  = '{8'h00, 1'b1, 1'b1, 3'd7, 8'h85, 1'b0};
    vecs[7]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h05, 1'b0};
    vecs[8]  = '{8'h00, 1'b1, 1'b1, 3'd2, 8'h05, 1'b0};
    vecs[9]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h01, 1'b0};
    vecs[10] = '{8'h00, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0};
    vecs[11] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[12] = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[13] = '{8'h08, 1'b0, 1'b0, 3'd0, 8'h08, 1'b0};
    vecs[14] = '{8'h00, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0};
    vecs[15] = '{8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b1};
    vecs[16] = '{8'h00, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0};
    vecs[17] = '{8'h08, 1'b1, 1'b0, 3'd0, 8'h08, 1'b0};
    vecs[18] = '{8'h00, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0};
    vecs[19] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[20] = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};

`ifdef ENCODER8_3_ROUND_ROBIN_EN
    exp_rr = '{3'd7, 3'd0, 3'd7, 3'd0};
`else
    exp_rr = '{3'd7, 3'd7, 3'd7, 3'd7};
`endif
    one8 = 8'h01;

    rst       = 1'b1;
    req       = 8'h00;
    out_ready = 1'b0;
    step();
    step();
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_code", 32'(code), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 21; i++) begin
      req       = vecs[i].req;
      out_ready = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].pend));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      if (vecs[i].valid) begin
        chk($sformatf("vec%0d_code", i), 32'(code), 32'(vecs[i].code));
      end
    end

    // Backpressure: code 1 held through a 5-cycle stall while bit 6 arrives.
    req       = 8'h02;
    out_ready = 1'b0;
    step();
    step();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_code", 32'(code), 32'd1);
    for (int s = 0; s < 5; s++) begin
      req = (s == 1) ? 8'h42 : 8'h02;
      step();
      chk($sformatf("bp_stall%0d_valid", s), 32'(out_valid), 32'd1);
      chk($sformatf("bp_stall%0d_code", s), 32'(code), 32'd1);
      chk($sformatf("bp_stall%0d_pending", s), 32'(pending), (s >= 1) ? 32'h42 : 32'h02);
    end
    out_ready = 1'b1;
    step();
    chk("bp_accept_valid", 32'(out_valid), 32'd0);
    chk("bp_accept_pending", 32'(pending), 32'h40);
    out_ready = 1'b0;
    step();
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_code", 32'(code), 32'd6);
    out_ready = 1'b1;
    step();
    chk("bp_drain_pending", 32'(pending), 32'h00);
    req       = 8'h00;
    out_ready = 1'b0;
    step();

    // Keep 8'h81 pending by re-pulsing the granted bit in its accept cycle.
    req = 8'h81;
    step();
    chk("rr_capture", 32'(pending), 32'h81);
    req = 8'h00;
    step();
    chk("rr_first_valid", 32'(out_valid), 32'd1);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rr_grant%0d_code", g), 32'(code), 32'(exp_rr[g]));
      req       = one8 << exp_rr[g];
      out_ready = 1'b1;
      step();
      chk($sformatf("rr_grant%0d_acc_valid", g), 32'(out_valid), 32'd0);
      chk($sformatf("rr_grant%0d_pending", g), 32'(pending), 32'h81);
      chk($sformatf("rr_grant%0d_ovf", g), 32'(ovf), 32'd0);
      req       = 8'h00;
      out_ready = 1'b0;
      step();
      chk($sformatf("rr_grant%0d_next_valid", g), 32'(out_valid), 32'd1);
    end

    // Reset mid-handshake with pending 8'hF0, then a req held across reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 8'hF0;
    step();
    req = 8'h00;
    step();
    chk("rst_pre_valid", 32'(out_valid), 32'd1);
    chk("rst_pre_code", 32'(code), 32'd7);
    chk("rst_pre_pending", 32'(pending), 32'hF0);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_code", 32'(code), 32'd0);
    chk("rst_async_pending", 32'(pending), 32'd0);
    chk("rst_async_ovf", 32'(ovf), 32'd0);
    req = 8'h01;
    step();
    step();
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < SS + 1; k++) begin
      step();
      chk($sformatf("rst_lat%0d_valid", k), 32'(out_valid), 32'd0);
    end
    step();
    chk("rst_post_valid", 32'(out_valid), 32'd1);
    chk("rst_post_code", 32'(code), 32'd0);
    out_ready = 1'b1;
    step();
    chk("rst_post_acc_pending", 32'(pending), 32'd0);
    out_ready = 1'b0;
    step();
    step();
    chk("rst_once_valid", 32'(out_valid), 32'd0);
    chk("rst_once_pending", 32'(pending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
